// File: rtl/jk_excitation_driver.sv
// Drives J/K from a FIFO of desired next-Q bits using the JK excitation table,
// then checks the flip-flop's Q one cycle later and counts mismatches.
module jk_excitation_driver #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8,
  parameter int DC_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tgt_valid,
  input  logic                     tgt_bit,
  output logic                     tgt_ready,
  input  logic                     start,
  input  logic                     clr_err,
  input  logic                     q_obs,
  output logic                     j,
  output logic                     k,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     err_flag,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic DC = DC_MODE[0];

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             j_q, j_d, k_q, k_d, done_q, done_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             model_q_q, model_q_d, exp_q, exp_d;
  logic             push, pop, head;

  // {j,k} needed to move Q from mq to e; the unused input takes DC.
  function automatic logic [1:0] excite(input logic mq, input logic e);
    if (!mq) return {e, DC};
    return {DC, ~e};
  endfunction

  assign tgt_ready = (level_q != LW'(DEPTH));
  assign push      = tgt_valid && tgt_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    j_d        = 1'b0;
    k_d        = 1'b0;
    done_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    model_q_d  = model_q_q;
    exp_d      = exp_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr_err) begin
          err_cnt_d  = '0;
          err_flag_d = 1'b0;
        end
        if (start && level_q != '0) begin
          pop        = 1'b1;
          exp_d      = head;
          {j_d, k_d} = excite(model_q_q, head);
          state_d    = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (q_obs != exp_q) begin
          err_flag_d = 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
        model_q_d = exp_q;
        if (level_q != '0) begin
          pop        = 1'b1;
          exp_d      = head;
          {j_d, k_d} = excite(exp_q, head);
          state_d    = DRIVE;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = tgt_bit;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      model_q_q  <= 1'b0;
      exp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      model_q_q  <= model_q_d;
      exp_q      <= exp_d;
    end
  end

  assign j        = j_q;
  assign k        = k_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
  assign level    = level_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Two drivers (DC_MODE 0 / CNT_W 8 and DC_MODE 1 / CNT_W 2) share stimulus;
// each drives its own ideal JK flip-flop, checked against a queue-based model.
module tb_jk_excitation_driver;
  localparam int DEPTH = 8;

  logic clk = 1'b0, rst = 1'b1, tgt_valid = 1'b0, tgt_bit = 1'b0;
  logic start = 1'b0, clr_err = 1'b0, tie0 = 1'b0;
  logic [1:0] ffq, q_obs_v, j_v, k_v, busy_v, done_v, ready_v, flag_v;
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic [3:0] lvl0, lvl1;

  int n_tests = 0, n_fail = 0;
  bit fq[$];
  int mq = 0, me0 = 0, me1 = 0, mflag = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(8), .DC_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(ready_v[0]),
    .start(start), .clr_err(clr_err), .q_obs(q_obs_v[0]), .j(j_v[0]), .k(k_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err_cnt(ec0), .err_flag(flag_v[0]), .level(lvl0));

  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(2), .DC_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(ready_v[1]),
    .start(start), .clr_err(clr_err), .q_obs(q_obs_v[1]), .j(j_v[1]), .k(k_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err_cnt(ec1), .err_flag(flag_v[1]), .level(lvl1));

  // Ideal JK flip-flops on the far side of each driver, reset to Q=0.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) ffq[n] <= 1'b0;
      else case ({j_v[n], k_v[n]})
        2'b01: ffq[n] <= 1'b0;
        2'b10: ffq[n] <= 1'b1;
        2'b11: ffq[n] <= ~ffq[n];
        default: ffq[n] <= ffq[n];
      endcase
    end
  end
  assign q_obs_v = tie0 ? 2'b00 : ffq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Excitation table rows: Q now -> desired Q, with d on the don't-care input.
  function automatic logic [1:0] exc(input int q, input int e, input int d);
    logic dd;
    dd = (d != 0);
    if (q == 0) return (e == 0) ? {1'b0, dd} : {1'b1, dd};
    return (e == 0) ? {dd, 1'b1} : {dd, 1'b0};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy0"}, busy_v[0], 0);
    chk({tag, "_busy1"}, busy_v[1], 0);
    chk({tag, "_jk0"}, {j_v[0], k_v[0]}, 0);
    chk({tag, "_jk1"}, {j_v[1], k_v[1]}, 0);
    chk({tag, "_lvl0"}, lvl0, fq.size());
    chk({tag, "_lvl1"}, lvl1, fq.size());
    chk({tag, "_rdy"}, ready_v, (fq.size() < DEPTH) ? 2'b11 : 2'b00);
    chk({tag, "_ec0"}, ec0, me0);
    chk({tag, "_ec1"}, ec1, me1);
    chk({tag, "_flag"}, flag_v, mflag ? 2'b11 : 2'b00);
  endtask

  task automatic push_bit(input bit b);
    tgt_valid = 1'b1;
    tgt_bit   = b;
    chk("push_rdy", ready_v[0], fq.size() < DEPTH);
    if (fq.size() < DEPTH) fq.push_back(b);
    step();
    tgt_valid = 1'b0;
    chk("push_lvl", lvl1, fq.size());
  endtask

  // Start in cycle 0; every cycle of the run is checked, done expected at 2N+1.
  // With noise, pushes/start/clr_err arrive during DRIVE cycles.
  task automatic run(input bit noise);
    bit b;
    int obs;
    start = 1'b1;
    chk("run_pre_busy", busy_v, 0);
    step();
    start = 1'b0;
    if (fq.size() == 0) begin
      chk("empty_start_busy", busy_v, 0);
      chk("empty_start_done", done_v, 0);
      step();
      chk("empty_start_done2", done_v, 0);
      return;
    end
    b = fq.pop_front();
    forever begin
      chk("drv_jk0", {j_v[0], k_v[0]}, exc(mq, b, 0));
      chk("drv_jk1", {j_v[1], k_v[1]}, exc(mq, b, 1));
      chk("drv_busy", busy_v, 2'b11);
      chk("drv_done", done_v, 0);
      chk("drv_lvl", lvl0, fq.size());
      if (noise) begin
        tgt_valid = 1'($urandom_range(0, 1));
        tgt_bit   = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        clr_err   = 1'b1;
        if (tgt_valid && fq.size() < DEPTH) fq.push_back(tgt_bit);
      end
      step();
      tgt_valid = 1'b0; start = 1'b0; clr_err = 1'b0;
      chk("chk_jk", {j_v, k_v}, 0);
      chk("chk_busy", busy_v, 2'b11);
      chk("chk_done", done_v, 0);
      chk("chk_q", q_obs_v, tie0 ? 2'b00 : {b, b});
      obs = tie0 ? 0 : int'(b);
      if (obs != int'(b)) begin
        mflag = 1;
        me0 = (me0 < 255) ? me0 + 1 : 255;
        me1 = (me1 < 3) ? me1 + 1 : 3;
      end
      mq = b;
      step();
      if (fq.size() != 0) b = fq.pop_front();
      else break;
    end
    chk("done_pulse", done_v, 2'b11);
    chk_idle("post_run");
    step();
    chk("done_drop", done_v, 0);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    me0 = 0; me1 = 0; mflag = 0;
    chk_idle("clr");
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_done", done_v, 0);
    chk_idle("reset");

    push_bit(1); push_bit(1); push_bit(0); push_bit(0);
    run(0);

    for (int i = 0; i < 9; i++) push_bit(1'($urandom_range(0, 1)));
    chk_idle("full");
    run(0);

    tie0 = 1'b1;
    push_bit(1); push_bit(1); push_bit(1);
    run(0);
    push_bit(1); push_bit(1);
    run(0);
    push_bit(1); push_bit(0);
    run(1);
    tie0 = 1'b0;
    clear_errs();

    run(0);

    push_bit(1); push_bit(0); push_bit(1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_busy", busy_v, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    fq.delete(); mq = 0; me0 = 0; me1 = 0; mflag = 0;
    chk("mid_rst_done", done_v, 0);
    chk_idle("mid_rst");
    step();
    chk("mid_rst_done2", done_v, 0);

    for (int it = 0; it < 30; it++) begin
      tie0 = ($urandom_range(0, 3) == 0);
      for (int i = $urandom_range(1, 9); i > 0; i--) push_bit(1'($urandom_range(0, 1)));
      run(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) clear_errs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
Stimulus generator and checker for the other end of a JK flip-flop interface. It accepts a queue of desired next-state bits and converts each one into J/K drive using the JK excitation table against an internal model of Q. It then checks the flip-flop's observed Q one cycle later and counts mismatches. It shares the FF's clock and sits between a bench or sequencer and any jk_ff instance.

Parameters:
DEPTH, 8, target FIFO entries (power of two, >=2)
CNT_W, 8, width of mismatch counter
DC_MODE, 0, value driven on don't-care J/K positions (0 or 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
tgt_valid  in  1  target bit offered
tgt_bit  in  1  desired next Q value
tgt_ready  out  1  FIFO can accept (= !full)
start  in  1  begin draining FIFO (sampled in IDLE only)
clr_err  in  1  clear err_cnt/err_flag (honoured in IDLE only)
q_obs  in  1  Q output of the driven flip-flop
j  out  1  J drive (registered)
k  out  1  K drive (registered)
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse on return to IDLE after a run
err_cnt  out  CNT_W  saturating mismatch count
err_flag  out  1  sticky, set on any mismatch
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, level=0, tgt_ready=1, FSM=IDLE, j=0, k=0, busy=0, done=0, err_cnt=0, err_flag=0, model_q=0, exp=0. Reset has priority over all other inputs in every state, including mid-run.
- FIFO: a push occurs when tgt_valid && tgt_ready. tgt_ready is combinational !full. When full, a push is refused even if a pop occurs in the same cycle. Simultaneous push and pop while not full leaves level unchanged. Pushes are allowed while busy. Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE: j=k=0 (FF holds).
  - start && level!=0: pop the head into exp, load j/k from the excitation table, go to DRIVE.
  - start && level==0: ignored; no done pulse.
  - clr_err: zeroes err_cnt and err_flag.
- Excitation table (model_q -> exp: j,k), where d=DC_MODE:
  - 0->0: 0,d
  - 0->1: 1,d
  - 1->0: d,1
  - 1->1: d,0
- DRIVE (1 cycle): j/k held stable; the FF samples them at the closing edge. On that edge j<=0, k<=0, go to CHECK.
- CHECK (1 cycle): q_obs is compared with exp at the closing edge.
  - On mismatch: err_flag<=1, and err_cnt increments unless already at 2^CNT_W-1 (saturates).
  - model_q<=exp.
  - If level!=0: pop the next entry, load j/k (computed from exp as the new model_q), go to DRIVE.
  - Else: go to IDLE with done<=1 for exactly one cycle.
- Throughput is 2 cycles per bit. With start high in cycle 0, bit i is driven in cycle 1+2i and checked in cycle 2+2i. For N bits, done is high in cycle 2N+1.
- start and clr_err asserted outside IDLE are ignored. busy=1 in DRIVE and CHECK.
- The model assumes the DUT also resets to Q=0. A DUT that resets differently shows as a mismatch on the first check.

Test Plan:
- Reset: hold rst 2 cycles -> j=0, k=0, busy=0, done=0, err_cnt=0, err_flag=0, level=0, tgt_ready=1.
- Ideal JK FF attached, DC_MODE=0, push 1,1,0,0, start in cycle 0 -> (j,k) = (1,0),(0,0),(0,1),(0,0) in cycles 1,3,5,7. q_obs = 1,1,0,0 in cycles 2,4,6,8. done=1 only in cycle 9; err_cnt=0.
- Same sequence with DC_MODE=1 -> (j,k) = (1,1),(1,0),(1,1),(0,1). FF Q still 1,1,0,0; err_cnt=0.
- Push 9 bits with no start -> level=8, tgt_ready=0 after the 8th, 9th bit dropped. Then start -> exactly 8 DRIVE/CHECK pairs and done in cycle 17.
- q_obs tied 0, targets 1,1,1 -> err_cnt=3, err_flag=1. clr_err in IDLE -> err_cnt=0, err_flag=0. clr_err asserted while busy -> no effect.
- CNT_W=2 with 5 forced mismatches -> err_cnt saturates at 3. Assert rst during a DRIVE cycle -> next cycle busy=0, level=0, j=k=0, no done pulse.
